// File: rtl/arbitro_rr_4a1_pkg.sv
// Shared definitions for the four-class round-robin merge arbiter.
// The class field occupies the top CLASS_W bits of every FIFO entry.
package arbitro_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;
   localparam int CLASS_W = 2;
   localparam int CNT_W   = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

endpackage

// File: rtl/arbitro_rr_4a1_if.sv
// Bus between the arbiter, the four class FIFOs and the shared downstream FIFO.
// master is the arbiter side, slave is the FIFO/environment side.
interface arbitro_rr_4a1_if #(
   parameter int DATA_WIDTH = 6
);
   import arbitro_pkg::*;

   logic                            Enable;
   logic [NUM_REQ-1:0]              FIFO_empty;
   logic [NUM_REQ*DATA_WIDTH-1:0]   FIFO_data;
   logic                            Almost_full;
   logic [NUM_REQ-1:0]              Pop;
   logic                            Push;
   logic [DATA_WIDTH-1:0]           data_out;
   logic [IDX_W-1:0]                grant_id;
   logic                            idle;

   modport master (
      input  Enable, FIFO_empty, FIFO_data, Almost_full,
      output Pop, Push, data_out, grant_id, idle
   );

   modport slave (
      output Enable, FIFO_empty, FIFO_data, Almost_full,
      input  Pop, Push, data_out, grant_id, idle
   );

endinterface

// File: rtl/arbitro_rr_4a1_rr_select.sv
// Circular first-set-bit finder: returns the first requester at or after
// start, wrapping modulo NUM_REQ.
module rr_select
   import arbitro_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   start,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   // Scanning from the farthest offset down lets the nearest hit win.
   always_comb begin
      found = 1'b0;
      idx   = start;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[start + IDX_W'(k)]) begin
            found = 1'b1;
            idx   = start + IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/arbitro_rr_4a1.sv
// Round-robin arbiter draining four class FIFOs into one downstream FIFO,
// with a per-requester burst quantum and a fixed two-cycle pop-to-push latency.
module arbitro_rr_4a1
   import arbitro_pkg::*;
#(
   parameter int DATA_WIDTH = 6,
   parameter int QUANTUM    = 2
)(
   input  logic             clk,
   input  logic             reset,
   arbitro_rr_4a1_if.master bus
);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     cur_q, cur_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [CNT_W-1:0]     burst_q, burst_d;
   logic [NUM_REQ-1:0]   pop_d;
   logic [IDX_W-1:0]     pop_idx;

   logic                 go;
   logic [NUM_REQ-1:0]   req;
   logic [IDX_W-1:0]     rr_start;
   logic                 rr_found;
   logic [IDX_W-1:0]     rr_idx;

   logic                 s1_valid;
   logic [IDX_W-1:0]     s1_idx;
   logic                 push_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [IDX_W-1:0]     gid_q;

   assign go  = bus.Enable & ~bus.Almost_full & ~reset;
   assign req = ~bus.FIFO_empty;

   // From IDLE the scan starts after the last served requester; while serving
   // it starts after the current one, so cur is only re-picked when alone.
   assign rr_start = (state_q == IDLE) ? last_q + 1'b1 : cur_q + 1'b1;

   rr_select u_rr_select (
      .req   (req),
      .start (rr_start),
      .found (rr_found),
      .idx   (rr_idx)
   );

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      last_d  = last_q;
      burst_d = burst_q;
      pop_d   = '0;
      pop_idx = cur_q;
      case (state_q)
         IDLE: begin
            if (go && rr_found) begin
               pop_d[rr_idx] = 1'b1;
               pop_idx       = rr_idx;
               cur_d         = rr_idx;
               burst_d       = CNT_W'(1);
               state_d       = SERVE;
            end
         end
         SERVE: begin
            if (go) begin
               if (req[cur_q] && (burst_q < CNT_W'(QUANTUM))) begin
                  pop_d[cur_q] = 1'b1;
                  burst_d      = burst_q + 1'b1;
               end else begin
                  last_d = cur_q;
                  if (rr_found) begin
                     pop_d[rr_idx] = 1'b1;
                     pop_idx       = rr_idx;
                     cur_d         = rr_idx;
                     burst_d       = CNT_W'(1);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
      endcase
   end

   // last_q resets to the highest index so requester 0 wins the first scan.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cur_q   <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         burst_q <= burst_d;
      end
   end

   // Stage 1 remembers which FIFO was popped; stage 2 captures its read data,
   // which the class FIFOs present one cycle after the pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         push_q   <= 1'b0;
         data_q   <= '0;
         gid_q    <= '0;
      end else begin
         s1_valid <= |pop_d;
         s1_idx   <= pop_idx;
         push_q   <= s1_valid;
         if (s1_valid) begin
            data_q <= bus.FIFO_data[int'(s1_idx) * DATA_WIDTH +: DATA_WIDTH];
            gid_q  <= s1_idx;
         end
      end
   end

   assign bus.Pop      = pop_d;
   assign bus.Push     = push_q;
   assign bus.data_out = data_q;
   assign bus.grant_id = gid_q;
   assign bus.idle     = (state_q == IDLE) & ~s1_valid & ~push_q;

endmodule

// File: tb/tb_arbitro_rr_4a1.sv
// Bench for arbitro_rr_4a1: per-scenario pop tables plus a push scoreboard
// fed from a behavioural model of the four registered-read class FIFOs.
module tb_arbitro_rr_4a1;
   import arbitro_pkg::*;

   localparam int DW = 6;
   localparam int QN = 2;

   typedef struct {
      int         scen;
      logic       en;
      logic       af;
      logic       rst;
      logic [3:0] pop;
   } vec_t;

   typedef struct {
      int               due;
      logic [IDX_W-1:0] idx;
      logic [DW-1:0]    data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   arbitro_rr_4a1_if #(.DATA_WIDTH(DW)) bus ();

   arbitro_rr_4a1 #(.DATA_WIDTH(DW), .QUANTUM(QN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   vec_t          vecs[$];
   exp_t          sb[$];
   logic [DW-1:0] fifo_q [NUM_REQ][$];
   int            errors = 0;
   int            checks = 0;
   int            cyc    = 0;
   int            seq    = 0;
   logic [DW-1:0] last_data = '0;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic addVec(input int scen, input logic en, input logic af, input logic rst, input logic [3:0] pop);
      vec_t v;
      v.scen = scen; v.en = en; v.af = af; v.rst = rst; v.pop = pop;
      vecs.push_back(v);
   endtask

   task automatic updateEmpty();
      for (int i = 0; i < NUM_REQ; i++) bus.FIFO_empty[i] = (fifo_q[i].size() == 0);
   endtask

   task automatic loadFifo(input int cls, input int n);
      logic [DW-1:0] v;
      for (int k = 0; k < n; k++) begin
         v = DW'(seq % 16);
         v[DW-1 -: CLASS_W] = CLASS_W'(cls);
         fifo_q[cls].push_back(v);
         seq++;
      end
      updateEmpty();
   endtask

   task automatic resetDut();
      reset = 1'b1;
      bus.Enable = 1'b1;
      bus.Almost_full = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) fifo_q[i].delete();
      updateEmpty();
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 0;
      checkOutput("rst_pop", 32'(bus.Pop), 32'd0);
      checkOutput("rst_push", 32'(bus.Push), 32'd0);
      checkOutput("rst_data_out", 32'(bus.data_out), 32'd0);
      checkOutput("rst_grant_id", 32'(bus.grant_id), 32'd0);
      checkOutput("rst_idle", 32'(bus.idle), 32'd1);
   endtask

   task automatic checkPush();
      exp_t e;
      if (bus.Push) begin
         if (sb.size() == 0) begin
            checkOutput("push_unexpected", 32'(bus.Push), 32'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("push_cycle", 32'(cyc), 32'(e.due));
            checkOutput("grant_id", 32'(bus.grant_id), 32'(e.idx));
            checkOutput("data_out", 32'(bus.data_out), 32'(e.data));
            last_data = e.data;
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         checkOutput("push_missing", 32'(bus.Push), 32'd1);
      end
   endtask

   task automatic applyStimulus(input int scen);
      logic [3:0] pop_seen;
      exp_t       e;
      exp_t       keep[$];
      foreach (vecs[k]) begin
         if (vecs[k].scen == scen) begin
            reset           = vecs[k].rst;
            bus.Enable      = vecs[k].en;
            bus.Almost_full = vecs[k].af;
            @(negedge clk);
            pop_seen = bus.Pop;
            checkOutput("pop", 32'(pop_seen), 32'(vecs[k].pop));
            checkPush();
            for (int i = 0; i < NUM_REQ; i++) begin
               if (pop_seen[i] && fifo_q[i].size() > 0) begin
                  e.due  = cyc + 2;
                  e.idx  = IDX_W'(i);
                  e.data = fifo_q[i][0];
                  sb.push_back(e);
               end
            end
            // A reset edge ends this cycle: anything still in the pipe is lost.
            if (vecs[k].rst) begin
               keep.delete();
               foreach (sb[j]) if (sb[j].due <= cyc) keep.push_back(sb[j]);
               sb = keep;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (pop_seen[i] && fifo_q[i].size() > 0)
                  bus.FIFO_data[i*DW +: DW] = fifo_q[i].pop_front();
            end
            updateEmpty();
            cyc++;
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.Enable = 1'b0;
      bus.Almost_full = 1'b0;
      bus.FIFO_empty = '1;
      bus.FIFO_data = '0;

      // 1: everything empty after reset
      for (int k = 0; k < 5; k++) addVec(1, 1, 0, 0, 4'b0000);
      // 2: four classes with three entries each, quantum 2
      addVec(2,1,0,0,4'b0001); addVec(2,1,0,0,4'b0001);
      addVec(2,1,0,0,4'b0010); addVec(2,1,0,0,4'b0010);
      addVec(2,1,0,0,4'b0100); addVec(2,1,0,0,4'b0100);
      addVec(2,1,0,0,4'b1000); addVec(2,1,0,0,4'b1000);
      addVec(2,1,0,0,4'b0001); addVec(2,1,0,0,4'b0010);
      addVec(2,1,0,0,4'b0100); addVec(2,1,0,0,4'b1000);
      for (int k = 0; k < 3; k++) addVec(2, 1, 0, 0, 4'b0000);
      // 3: only class 2, five entries, re-granted to itself
      for (int k = 0; k < 5; k++) addVec(3, 1, 0, 0, 4'b0100);
      for (int k = 0; k < 3; k++) addVec(3, 1, 0, 0, 4'b0000);
      // 4: Almost_full for cycles 4..6, class 2 resumes its burst
      addVec(4,1,0,0,4'b0001); addVec(4,1,0,0,4'b0010);
      addVec(4,1,0,0,4'b0010); addVec(4,1,0,0,4'b0100);
      addVec(4,1,1,0,4'b0000); addVec(4,1,1,0,4'b0000); addVec(4,1,1,0,4'b0000);
      addVec(4,1,0,0,4'b0100); addVec(4,1,0,0,4'b0010);
      addVec(4,1,0,0,4'b0010); addVec(4,1,0,0,4'b0100);
      addVec(4,1,0,0,4'b0100);
      for (int k = 0; k < 3; k++) addVec(4, 1, 0, 0, 4'b0000);
      // 5: Enable low for three cycles in the middle of a class 1 burst
      addVec(5,1,0,0,4'b0010);
      addVec(5,0,0,0,4'b0000); addVec(5,0,0,0,4'b0000); addVec(5,0,0,0,4'b0000);
      addVec(5,1,0,0,4'b0010); addVec(5,1,0,0,4'b0100);
      addVec(5,1,0,0,4'b0100); addVec(5,1,0,0,4'b0010);
      addVec(5,1,0,0,4'b0010);
      for (int k = 0; k < 3; k++) addVec(5, 1, 0, 0, 4'b0000);
      // 6: reset one cycle after a pop, requester 0 wins afterwards
      addVec(6,1,0,0,4'b0001); addVec(6,1,0,0,4'b0001);
      addVec(6,1,0,0,4'b0010); addVec(6,1,0,1,4'b0000);
      addVec(6,1,0,0,4'b0001); addVec(6,1,0,0,4'b0010);
      for (int k = 0; k < 3; k++) addVec(6, 1, 0, 0, 4'b0000);

      for (int scen = 1; scen <= 6; scen++) begin
         resetDut();
         case (scen)
            2: for (int i = 0; i < NUM_REQ; i++) loadFifo(i, 3);
            3: loadFifo(2, 5);
            4: begin loadFifo(0, 1); loadFifo(1, 4); loadFifo(2, 4); end
            5: begin loadFifo(1, 4); loadFifo(2, 2); end
            6: begin loadFifo(0, 3); loadFifo(1, 2); end
            default: ;
         endcase
         applyStimulus(scen);
         checkOutput("idle_end", 32'(bus.idle), 32'd1);
         checkOutput("push_end", 32'(bus.Push), 32'd0);
         if (scen == 1) checkOutput("data_out_empty", 32'(bus.data_out), 32'd0);
         if (scen == 2) checkOutput("data_hold", 32'(bus.data_out), 32'(last_data));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/arbitro_rr_4a1.md
Name: arbitro_rr_4a1

Overview:
- Transaction-layer round-robin arbiter that merges four per-class input FIFOs (classes 0..3) into one downstream FIFO.
- Sits upstream of the class-demux arbiter: it drains the class FIFOs fairly and, one entry per cycle, pushes into the shared FIFO.
- Holds a per-requester burst quantum before rotating, and stalls on downstream almost-full.

Parameters:
- DATA_WIDTH, 6, width of one FIFO entry (class field in bits [DATA_WIDTH-1:DATA_WIDTH-2]).
- QUANTUM, 2, maximum consecutive grants to one requester before rotation (1..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Enable  input  1  when low, no new pops issue; in-flight entries still complete
- FIFO_empty  input  4  per-class input FIFO empty flags, bit i = class i
- FIFO_data  input  4*DATA_WIDTH  read data of class FIFOs, slice i = [i*DATA_WIDTH +: DATA_WIDTH]; registered read, valid the cycle after pop
- Almost_full  input  1  downstream FIFO almost-full
- Pop  output  4  one-hot pop to class FIFOs, combinational from registered state plus inputs
- Push  output  1  registered push to downstream FIFO
- data_out  output  DATA_WIDTH  registered data to downstream FIFO
- grant_id  output  2  registered index of requester whose entry is on data_out
- idle  output  1  high when state IDLE and no entry in flight

Behaviour:
- Reset (clk edge with reset=1): Push=0, data_out=0, grant_id=0, state=IDLE, last_grant=3 (requester 0 wins first), burst_cnt=0, pipeline valid bits=0. Pop is 0 while reset=1.
- Issue condition, cycle t: go = Enable & !Almost_full & !reset.
- IDLE:
  - If go and any requester is non-empty, select the first non-empty index scanning last_grant+1, +2, +3, +4 (mod 4).
  - Assert Pop[sel]; cur<=sel; burst_cnt<=1; state<=SERVE.
- SERVE:
  - If go, FIFO_empty[cur]=0 and burst_cnt<QUANTUM: Pop[cur], burst_cnt++.
  - Otherwise, if go: last_grant<=cur; pick the next requester by RR scan from cur+1, skipping cur unless it is the only non-empty one. Pop it, burst_cnt<=1. If none is non-empty, state<=IDLE with no pop.
  - If !go: no pop, state and burst_cnt hold.
- Pipeline, fixed latency 2:
  - Pop at cycle t; FIFO_data valid at t+1.
  - At the edge ending t+1, capture the slice of the granted index.
  - Push=1, data_out and grant_id valid during t+2.
  - Stage-1 register holds {valid, idx}; stage-2 drives the outputs. Push=0 whenever stage-2 is invalid; data_out then holds its last value.
- Throughput: one entry per cycle when go stays high and entries are available.
- Backpressure: at most 2 entries are in flight after Almost_full rises; the downstream almost-full threshold must leave at least 2 free slots.
- Enable low mid-burst: pops stop next cycle; in-flight entries still push; burst_cnt is preserved.
- Never pop an empty FIFO. Pop is always one-hot or zero.
- Reset mid-operation: in-flight valid bits are cleared; popped entries are dropped with no push.
- Simultaneous Almost_full rise and requester becoming non-empty: no pop that cycle.

Decomposition:
- Shared package (arbitro_pkg): NUM_REQ=4, IDX_W=2, state encoding IDLE=1'b0 and SERVE=1'b1, and class field position constants.
- Sub-module rr_select: combinational; inputs req[3:0] and start index; outputs found and idx of the first set bit at or after start (mod 4). It is used for both IDLE and rotate decisions.

Test Plan:
- Reset, then all FIFOs empty for 5 cycles -> Pop=0, Push=0, idle=1, data_out=0.
- Classes 0..3 each hold 3 entries, QUANTUM=2, go held high -> Pop sequence 0,0,1,1,2,2,3,3,0,1,2,3. Push follows 2 cycles later with matching grant_id and data.
- Only class 2 non-empty with 5 entries -> Pop[2] 5 consecutive cycles, with re-grant to itself after quantum expiry. 5 pushes, then return to IDLE.
- Almost_full asserted in cycle 4 of a stream -> no Pop from cycle 4. Exactly 2 more pushes (cycles 4,5), then Push=0 until release. After release, pops resume at the held requester and burst_cnt.
- Enable dropped for 3 cycles mid-burst on class 1 -> in-flight entries pushed, no pops for 3 cycles. After re-enable, class 1 completes its remaining quantum.
- Reset asserted one cycle after a Pop -> no Push in the following cycles; after release, the next grant goes to requester 0.
